// File: rtl/source_operand_dispatch.sv
// Routes source operands into one registered slot per functional unit.
// Out-of-range selects are dropped and counted; flush and reset empty every slot.
module source_operand_dispatch #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NUM_UNITS = 3,
    parameter int unsigned SEL_W     = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          flush,
    input  logic                          src_valid,
    output logic                          src_ready,
    input  logic [SEL_W-1:0]              src_sel,
    input  logic [DATA_W-1:0]             src_value,
    output logic [NUM_UNITS-1:0]          unit_valid,
    input  logic [NUM_UNITS-1:0]          unit_ready,
    output logic [NUM_UNITS*DATA_W-1:0]   unit_value,
    output logic                          bad_sel,
    output logic [7:0]                    drop_count,
    output logic [15:0]                   dispatch_count
);

    localparam logic [SEL_W:0] UNITS_LIM = (SEL_W+1)'(NUM_UNITS);

    logic                 in_range;
    logic                 slot_free;
    logic                 fire_in;
    logic                 fire_bad;
    logic [NUM_UNITS-1:0] sel_hot;

    // Decode the select and decide whether the offered operand can be taken now.
    always_comb begin
        in_range  = {1'b0, src_sel} < UNITS_LIM;
        sel_hot   = '0;
        slot_free = 1'b0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (in_range && (src_sel == SEL_W'(k))) begin
                sel_hot[k] = 1'b1;
                slot_free  = !unit_valid[k] || unit_ready[k];
            end
        end
        if (in_range) begin
            src_ready = slot_free && !flush && !rst;
        end else begin
            src_ready = !flush && !rst;
        end
        fire_in  = src_valid && src_ready && in_range;
        fire_bad = src_valid && src_ready && !in_range;
    end

    // Slot registers and counters; reset beats flush, flush beats accept and consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            unit_valid     <= '0;
            unit_value     <= '0;
            bad_sel        <= 1'b0;
            drop_count     <= '0;
            dispatch_count <= '0;
        end else begin
            bad_sel <= fire_bad;
            if (fire_bad && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 8'd1;
            end
            if (fire_in) begin
                dispatch_count <= dispatch_count + 16'd1;
            end
            for (int k = 0; k < NUM_UNITS; k++) begin
                if (flush) begin
                    unit_valid[k] <= 1'b0;
                end else if (fire_in && sel_hot[k]) begin
                    unit_valid[k]                   <= 1'b1;
                    unit_value[k*DATA_W +: DATA_W] <= src_value;
                end else if (unit_ready[k]) begin
                    unit_valid[k] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_source_operand_dispatch.sv
// Scoreboard bench for source_operand_dispatch: the driver queues expected
// operands and drop counts, a negedge monitor checks them as units consume.
module tb_source_operand_dispatch;

    localparam int unsigned DW = 32;
    localparam int unsigned NU = 3;
    localparam int unsigned SW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              src_valid;
    logic              src_ready;
    logic [SW-1:0]     src_sel;
    logic [DW-1:0]     src_value;
    logic [NU-1:0]     unit_valid;
    logic [NU-1:0]     unit_ready;
    logic [NU*DW-1:0]  unit_value;
    logic              bad_sel;
    logic [7:0]        drop_count;
    logic [15:0]       dispatch_count;

    int total = 0;
    int bad   = 0;
    int exp_drop = 0;

    logic [31:0] q0[$];
    logic [31:0] q1[$];
    logic [31:0] q2[$];
    logic [7:0]  bq[$];

    source_operand_dispatch #(.DATA_W(DW), .NUM_UNITS(NU), .SEL_W(SW)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .src_valid      (src_valid),
        .src_ready      (src_ready),
        .src_sel        (src_sel),
        .src_value      (src_value),
        .unit_valid     (unit_valid),
        .unit_ready     (unit_ready),
        .unit_value     (unit_value),
        .bad_sel        (bad_sel),
        .drop_count     (drop_count),
        .dispatch_count (dispatch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] uval(input int k);
        return unit_value[k*DW +: DW];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] v);
        case (k)
            0: q0.push_back(v);
            1: q1.push_back(v);
            default: q2.push_back(v);
        endcase
    endtask

    task automatic clear_q();
        q0.delete();
        q1.delete();
        q2.delete();
        bq.delete();
    endtask

    task automatic pop_chk(input int k);
        logic [31:0] e;
        logic        ok;
        ok = 1'b1;
        e  = '0;
        case (k)
            0: if (q0.size() > 0) e = q0.pop_front(); else ok = 1'b0;
            1: if (q1.size() > 0) e = q1.pop_front(); else ok = 1'b0;
            default: if (q2.size() > 0) e = q2.pop_front(); else ok = 1'b0;
        endcase
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL unit%0d_unexpected act=0x%0h exp=none", k, uval(k));
        end else begin
            chk($sformatf("unit%0d_value", k), uval(k), e);
        end
    endtask

    // Monitor: every consume must match the oldest queued operand for that unit.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            for (int k = 0; k < NU; k++) begin
                if (unit_valid[k] && unit_ready[k]) pop_chk(k);
            end
            if (bad_sel) begin
                if (bq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL bad_sel_unexpected act=1 exp=0");
                end else begin
                    chk("drop_count_at_pulse", 32'(drop_count), 32'(bq.pop_front()));
                end
            end
        end
    end

    // One clock of stimulus; expected results are queued from the bench's own expectations.
    task automatic cyc(input logic v, input logic [1:0] sel, input logic [31:0] val,
                       input logic [2:0] rdy, input logic fl, input logic exp_rdy);
        src_valid  = v;
        src_sel    = sel;
        src_value  = val;
        unit_ready = rdy;
        flush      = fl;
        @(negedge clk);
        if (v) begin
            chk("src_ready", 32'(src_ready), 32'(exp_rdy));
            if (exp_rdy) begin
                if (sel < 2'd3) begin
                    push(int'(sel), val);
                end else begin
                    if (exp_drop != 255) exp_drop++;
                    bq.push_back(8'(exp_drop));
                end
            end
        end
        @(posedge clk);
        #1;
        src_valid  = 1'b0;
        unit_ready = '0;
        flush      = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        flush      = 1'b0;
        src_valid  = 1'b0;
        src_sel    = '0;
        src_value  = '0;
        unit_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        src_valid = 1'b1;
        src_sel   = 2'd1;
        src_value = 32'h5A;
        @(negedge clk);
        chk("rst_src_ready", 32'(src_ready), 32'h0);
        chk("rst_unit_valid", 32'(unit_valid), 32'h0);
        chk("rst_unit_value", 32'(|unit_value), 32'h0);
        chk("rst_bad_sel", 32'(bad_sel), 32'h0);
        chk("rst_drop", 32'(drop_count), 32'h0);
        chk("rst_dispatch", 32'(dispatch_count), 32'h0);
        @(posedge clk);
        #1;
        src_valid = 1'b0;
        rst       = 1'b0;

        // Single accept, then blocked second offer, then consume and idle strobes.
        cyc(1'b1, 2'd1, 32'hAB, 3'b000, 1'b0, 1'b1);
        chk("a_valid", 32'(unit_valid), 32'h2);
        chk("a_value1", uval(1), 32'hAB);
        chk("a_dispatch", 32'(dispatch_count), 32'h1);
        cyc(1'b1, 2'd1, 32'hCD, 3'b000, 1'b0, 1'b0);
        cyc(1'b0, 2'd0, 32'h0, 3'b010, 1'b0, 1'b0);
        chk("a_valid_after_consume", 32'(unit_valid), 32'h0);
        chk("a_value1_retained", uval(1), 32'hAB);
        cyc(1'b0, 2'd0, 32'h0, 3'b111, 1'b0, 1'b0);
        chk("a_ready_on_empty", 32'(unit_valid), 32'h0);

        // Replace-on-consume and a ten-deep back-to-back stream on unit 0.
        cyc(1'b1, 2'd0, 32'h1111, 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 2'd0, 32'h1234, 3'b001, 1'b0, 1'b1);
        chk("b_valid0", 32'(unit_valid[0]), 32'h1);
        chk("b_value0", uval(0), 32'h1234);
        for (int i = 0; i < 10; i++) cyc(1'b1, 2'd0, 32'h100 + 32'(i), 3'b001, 1'b0, 1'b1);
        chk("b_dispatch", 32'(dispatch_count), 32'd13);
        chk("b_value0_last", uval(0), 32'h109);
        cyc(1'b0, 2'd0, 32'h0, 3'b001, 1'b0, 1'b0);
        chk("b_drained", 32'(unit_valid), 32'h0);

        // Only the selected slot changes.
        cyc(1'b1, 2'd2, 32'h22, 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 2'd1, 32'h11, 3'b000, 1'b0, 1'b1);
        chk("c_valid", 32'(unit_valid), 32'h6);
        chk("c_value0", uval(0), 32'h109);
        chk("c_value1", uval(1), 32'h11);
        chk("c_value2", uval(2), 32'h22);
        chk("c_dispatch", 32'(dispatch_count), 32'd15);

        // Out-of-range selects: pulse, count, saturate at 255.
        cyc(1'b1, 2'd3, 32'hDEAD, 3'b000, 1'b0, 1'b1);
        chk("d_valid", 32'(unit_valid), 32'h6);
        chk("d_bad_sel", 32'(bad_sel), 32'h1);
        chk("d_drop", 32'(drop_count), 32'h1);
        cyc(1'b0, 2'd0, 32'h0, 3'b000, 1'b0, 1'b0);
        chk("d_bad_sel_low", 32'(bad_sel), 32'h0);
        for (int i = 0; i < 299; i++) cyc(1'b1, 2'd3, 32'(i), 3'b000, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 32'h0, 3'b000, 1'b0, 1'b0);
        chk("d_drop_sat", 32'(drop_count), 32'd255);
        chk("d_valid_kept", 32'(unit_valid), 32'h6);
        chk("d_dispatch", 32'(dispatch_count), 32'd15);

        // Flush with units 0 and 2 full and a concurrent offer.
        cyc(1'b0, 2'd0, 32'h0, 3'b010, 1'b0, 1'b0);
        cyc(1'b1, 2'd0, 32'h55, 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 2'd1, 32'h77, 3'b000, 1'b1, 1'b0);
        clear_q();
        chk("e_valid", 32'(unit_valid), 32'h0);
        chk("e_value0", uval(0), 32'h55);
        chk("e_value1", uval(1), 32'h11);
        chk("e_value2", uval(2), 32'h22);
        chk("e_dispatch", 32'(dispatch_count), 32'd16);
        chk("e_drop", 32'(drop_count), 32'd255);

        // Fresh reset, then 65536 accepts wrap the dispatch counter.
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        exp_drop = 0;
        chk("f_dispatch_rst", 32'(dispatch_count), 32'h0);
        for (int i = 0; i < 65536; i++) begin
            cyc(1'b1, 2'd0, 32'(i), 3'b001, 1'b0, 1'b1);
            if (i == 65534) chk("f_dispatch_max", 32'(dispatch_count), 32'd65535);
        end
        chk("f_dispatch_wrap", 32'(dispatch_count), 32'h0);
        chk("f_value0", uval(0), 32'hFFFF);

        // Reset with every slot full, a pending drop pulse and a simultaneous flush.
        cyc(1'b1, 2'd1, 32'hAAA, 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 2'd2, 32'hBBB, 3'b000, 1'b0, 1'b1);
        cyc(1'b1, 2'd3, 32'hCCC, 3'b000, 1'b0, 1'b1);
        chk("g_full", 32'(unit_valid), 32'h7);
        rst = 1'b1;
        cyc(1'b1, 2'd1, 32'h99, 3'b000, 1'b1, 1'b0);
        clear_q();
        exp_drop = 0;
        chk("g_valid", 32'(unit_valid), 32'h0);
        chk("g_value", 32'(|unit_value), 32'h0);
        chk("g_bad_sel", 32'(bad_sel), 32'h0);
        chk("g_drop", 32'(drop_count), 32'h0);
        chk("g_dispatch", 32'(dispatch_count), 32'h0);
        rst = 1'b0;

        // Still operational after reset.
        cyc(1'b1, 2'd2, 32'h42, 3'b000, 1'b0, 1'b1);
        cyc(1'b0, 2'd0, 32'h0, 3'b100, 1'b0, 1'b0);
        chk("h_dispatch", 32'(dispatch_count), 32'h1);
        chk("h_q_empty", 32'(q0.size() + q1.size() + q2.size() + bq.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/source_operand_dispatch.md
SOURCE_OPERAND_DISPATCH -- requirements
Module: source_operand_dispatch

Interface
REQ-001: Parameter DATA_W, default 32, width of the operand value.
REQ-002: Parameter NUM_UNITS, default 3, number of functional-unit destinations (unit 0 = ADD, 1 = MULT, 2 = MULADD at default).
REQ-003: Parameter SEL_W, default 2, width of the unit select; SHALL satisfy 2**SEL_W >= NUM_UNITS.
REQ-004: clk  input  1  single clock; all state updates on its rising edge.
REQ-005: rst  input  1  synchronous, active-high reset.
REQ-006: flush  input  1  discards all pending operands.
REQ-007: src_valid  input  1  source operand offered.
REQ-008: src_ready  output  1  operand accepted this cycle when src_valid=1.
REQ-009: src_sel  input  SEL_W  destination unit index.
REQ-010: src_value  input  DATA_W  operand value.
REQ-011: unit_valid  output  NUM_UNITS  per-unit operand-present flag.
REQ-012: unit_ready  input  NUM_UNITS  per-unit consume strobe.
REQ-013: unit_value  output  NUM_UNITS*DATA_W  per-unit operand; unit k occupies bits [k*DATA_W +: DATA_W].
REQ-014: bad_sel  output  1  one-cycle pulse when an operand with an out-of-range select is dropped.
REQ-015: drop_count  output  8  saturating count of dropped operands.
REQ-016: dispatch_count  output  16  wrapping count of operands delivered into unit slots.

Function
REQ-017: Each unit k SHALL own one registered slot (value register + valid flag); no combinational path from src_value to unit_value.
REQ-018: Transfer on the src side SHALL occur when src_valid=1 and src_ready=1; transfer on unit k when unit_valid[k]=1 and unit_ready[k]=1.
REQ-019: For src_sel < NUM_UNITS, src_ready SHALL equal (!unit_valid[src_sel] || unit_ready[src_sel]) && !flush && !rst.
REQ-020: For src_sel >= NUM_UNITS, src_ready SHALL be 1 (when !flush && !rst); the operand is dropped, bad_sel pulses the following cycle, and drop_count increments, saturating at 255.
REQ-021: An accepted in-range operand SHALL appear on unit_value[src_sel] with unit_valid[src_sel]=1 on the cycle after acceptance (latency 1).
REQ-022: Simultaneous consume and accept on the same unit SHALL replace the slot contents with the new operand, keeping unit_valid=1; sustained throughput SHALL be one operand per cycle per unit.
REQ-023: A consume without a new accept SHALL clear unit_valid[k] next cycle; unit_value[k] SHALL retain its last value (slots never accept data not selected to them).
REQ-024: Only the selected slot SHALL change on acceptance; all other slots hold value and valid state.
REQ-025: dispatch_count SHALL increment by 1 per accepted in-range operand, wrapping 65535 -> 0.
REQ-026: flush SHALL clear all unit_valid bits next cycle, force src_ready=0 that cycle, and leave unit_value, dispatch_count, and drop_count unchanged; flush takes priority over simultaneous accept and consume.
REQ-027: unit_ready[k] asserted while unit_valid[k]=0 SHALL have no effect.
REQ-028: src_value and src_sel SHALL be ignored when src_valid=0.

Reset
REQ-029: On rst=1 at a clock edge: unit_valid=0, unit_value=0, bad_sel=0, drop_count=0, dispatch_count=0.
REQ-030: While rst=1, src_ready SHALL be 0; rst asserted mid-transfer SHALL discard every pending operand, and rst SHALL take priority over flush.

Verification
REQ-031: After reset, src_sel=1, src_value=0x0000_00AB, src_valid=1, all unit_ready=0 -> next cycle unit_valid=3'b010, unit 1 value 0xAB, dispatch_count=1; a second sel=1 offer sees src_ready=0.
REQ-032: Unit 0 slot full, unit_ready[0]=1, new sel=0 value 0x1234 offered -> src_ready=1; next cycle unit_valid[0]=1 with value 0x1234; back-to-back stream of 10 operands -> 10 delivered, 1 per cycle.
REQ-033: src_sel=3 with NUM_UNITS=3 -> src_ready=1, bad_sel pulse for 1 cycle, drop_count=1, unit_valid unchanged; 300 such operands -> drop_count=255.
REQ-034: Units 0 and 2 full; flush=1 together with src_valid=1 sel=1 -> src_ready=0, next cycle unit_valid=0, unit_value unchanged, dispatch_count unchanged.
REQ-035: 65536 accepted in-range operands from reset -> dispatch_count=0; rst asserted with all slots full -> next cycle every output at its reset value.
